// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM and a
// one-entry holding register with ready/overrun/framing-error flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       rx,
  input  logic       read,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ready,
  output logic       overrun,
  output logic       frame_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          rx_m, rx_s;
  logic          load_good, load_bad;

  // Synchroniser presets to the idle-high line level.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  // A low level while idle is taken as the start edge; the counter restarts
  // at every bit boundary so it never needs to wrap.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    idx_n     = idx;
    shift_n   = shift;
    load_good = 1'b0;
    load_bad  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          state_n   = IDLE;
          load_good = rx_s;
          load_bad  = ~rx_s;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A good load beats a coincident read: ready stays set, overrun is only
  // raised when the previous byte was unread and not being read now.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_ready    <= 1'b0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_valid <= load_good;
      if (load_good) begin
        rx_data     <= shift;
        rx_ready    <= 1'b1;
        overrun     <= (rx_ready | overrun) & ~read;
        frame_error <= frame_error & ~read;
      end else begin
        if (read) begin
          rx_ready <= 1'b0;
          overrun  <= 1'b0;
        end
        frame_error <= load_bad | (frame_error & ~read);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
